// File: rtl/spike_count_classifier.sv
// spike_count_classifier: per-neuron spike counting over a strobe window, sequential argmax, valid/ready result
// Ports:
//   system_clock, rst_n (async, active low)  - clock and reset
//   enable        - run enable; low returns to IDLE and clears all state
//   window_len    - strobes per window, latched at window start (0 acts as 1)
//   spikes_valid  - strobe qualifying spikes
//   spikes        - one bit per output neuron
//   result_ready  - consumer accepts result
//   result_valid, class_id, class_count, tie - winning class, its count, tie flag
//   overrun       - sticky: a strobe arrived while busy
//   busy          - argmax scan or result hold in progress
module spike_count_classifier #(
    parameter int N_OUT = 8,
    parameter int CNT_W = 8,
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             system_clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       window_len,
    input  logic             spikes_valid,
    input  logic [N_OUT-1:0] spikes,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [IW-1:0]    class_id,
    output logic [CNT_W-1:0] class_count,
    output logic             tie,
    output logic             overrun,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, HOLD} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [N_OUT];
    logic [7:0]       samp_q, len_q;
    logic [IW-1:0]    idx_q, max_idx_q, max_idx_d, class_id_q;
    logic [CNT_W-1:0] max_q, max_d, cur, class_count_q;
    logic             tie_q, tie_d, class_tie_q, valid_q, overrun_q, busy_q;
    logic             gt, eq;
    logic [7:0]       len_eff;
    assign len_eff = (window_len == 8'd0) ? 8'd1 : window_len;
    // One scan step: strictly greater replaces, so the lowest index keeps ties
    assign cur       = cnt_q[idx_q];
    assign gt        = cur > max_q;
    assign eq        = (cur == max_q) && (cur != '0);
    assign max_d     = gt ? cur : max_q;
    assign max_idx_d = gt ? idx_q : max_idx_q;
    assign tie_d     = gt ? 1'b0 : (tie_q | eq);
    assign result_valid = valid_q;
    assign class_id     = class_id_q;
    assign class_count  = class_count_q;
    assign tie          = class_tie_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
            samp_q <= '0;
            len_q <= 8'd1;
            idx_q <= '0;
            max_q <= '0;
            max_idx_q <= '0;
            tie_q <= 1'b0;
            class_id_q <= '0;
            class_count_q <= '0;
            class_tie_q <= 1'b0;
            valid_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
            samp_q <= '0;
            len_q <= 8'd1;
            idx_q <= '0;
            max_q <= '0;
            max_idx_q <= '0;
            tie_q <= 1'b0;
            class_id_q <= '0;
            class_count_q <= '0;
            class_tie_q <= 1'b0;
            valid_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= ACCUM;
                    len_q <= len_eff;
                    samp_q <= '0;
                end
                ACCUM: if (spikes_valid) begin
                    // Counters saturate at all-ones instead of wrapping
                    for (int i = 0; i < N_OUT; i++)
                        cnt_q[i] <= (spikes[i] && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
                    samp_q <= samp_q + 8'd1;
                    if (samp_q + 8'd1 == len_q) begin
                        state_q <= ARGMAX;
                        busy_q <= 1'b1;
                        idx_q <= '0;
                        max_q <= '0;
                        max_idx_q <= '0;
                        tie_q <= 1'b0;
                    end
                end
                ARGMAX: begin
                    if (spikes_valid) overrun_q <= 1'b1;
                    max_q <= max_d;
                    max_idx_q <= max_idx_d;
                    tie_q <= tie_d;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(N_OUT - 1)) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                        class_id_q <= max_idx_d;
                        class_count_q <= max_d;
                        class_tie_q <= tie_d;
                    end
                end
                HOLD: begin
                    if (spikes_valid) overrun_q <= 1'b1;
                    if (result_ready) begin
                        state_q <= ACCUM;
                        valid_q <= 1'b0;
                        busy_q <= 1'b0;
                        for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
                        samp_q <= '0;
                        max_q <= '0;
                        max_idx_q <= '0;
                        tie_q <= 1'b0;
                        len_q <= len_eff;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_count_classifier.sv
// tb_spike_count_classifier: directed table-driven bench for spike_count_classifier
module tb_spike_count_classifier;
    logic       clk = 1'b0;
    logic       rst_n, enable, spikes_valid, result_ready;
    logic [7:0] window_len, spikes;
    logic       result_valid, tie, overrun, busy;
    logic [2:0] class_id;
    logic [7:0] class_count;
    int total = 0, bad = 0;

    spike_count_classifier dut (
        .system_clock(clk), .rst_n(rst_n), .enable(enable), .window_len(window_len),
        .spikes_valid(spikes_valid), .spikes(spikes), .result_ready(result_ready),
        .result_valid(result_valid), .class_id(class_id), .class_count(class_count),
        .tie(tie), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] wl;
        logic [7:0] sp;
        int         n;
        int         id;
        int         cnt;
        logic       tie;
    } vec_t;
    vec_t tv [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] sp);
        spikes_valid = 1'b1;
        spikes = sp;
        tick();
        spikes_valid = 1'b0;
        spikes = 8'h00;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic start(input logic [7:0] wl);
        enable = 1'b0;
        tick();
        window_len = wl;
        enable = 1'b1;
        tick();
    endtask

    int  lat;
    logic frozen;

    initial begin
        tv[0] = '{8'd4, 8'b0000_0100, 4, 2, 4, 1'b0};
        tv[1] = '{8'd3, 8'b1000_0010, 3, 1, 3, 1'b1};
        tv[2] = '{8'd5, 8'b0000_0000, 5, 0, 0, 1'b0};
        tv[3] = '{8'd0, 8'b0010_0000, 1, 5, 1, 1'b0};
        tv[4] = '{8'd2, 8'b1111_1111, 2, 0, 2, 1'b1};
        tv[5] = '{8'd6, 8'b1000_0000, 6, 7, 6, 1'b0};
        rst_n = 1'b0; enable = 1'b0; spikes_valid = 1'b0; spikes = 8'h00;
        result_ready = 1'b0; window_len = 8'd4;
        repeat (2) tick();
        chk("rst_valid", result_valid, 0);
        chk("rst_id", class_id, 0);
        chk("rst_cnt", class_count, 0);
        chk("rst_tie", tie, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start(tv[i].wl);
            for (int k = 0; k < tv[i].n; k++) strobe(tv[i].sp);
            chk($sformatf("v%0d_busy", i), busy, 1);
            wait_valid(lat);
            chk($sformatf("v%0d_lat", i), lat, 8);
            chk($sformatf("v%0d_id", i), class_id, tv[i].id);
            chk($sformatf("v%0d_cnt", i), class_count, tv[i].cnt);
            chk($sformatf("v%0d_tie", i), tie, tv[i].tie);
            tick();
            chk($sformatf("v%0d_onecyc", i), result_valid, 0);
        end

        // Full 255-strobe windows: neuron 5 reaches the top of the counter range
        start(8'd255);
        for (int k = 0; k < 255; k++) strobe(k < 100 ? 8'h21 : 8'h20);
        wait_valid(lat);
        chk("sat1_id", class_id, 5);
        chk("sat1_cnt", class_count, 255);
        chk("sat1_tie", tie, 0);
        tick();
        for (int k = 0; k < 255; k++) strobe(8'h20);
        wait_valid(lat);
        chk("sat2_cnt", class_count, 255);
        chk("sat2_id", class_id, 5);
        tick();

        // Backpressure with strobes during HOLD
        result_ready = 1'b0;
        start(8'd2);
        strobe(8'h08);
        strobe(8'h08);
        wait_valid(lat);
        chk("bp_lat", lat, 8);
        frozen = 1'b1;
        for (int k = 0; k < 20; k++) begin
            spikes_valid = 1'b1;
            spikes = 8'hFF;
            tick();
            if (class_id !== 3'd3 || class_count !== 8'd2 || result_valid !== 1'b1 || tie !== 1'b0) frozen = 1'b0;
        end
        spikes_valid = 1'b0;
        spikes = 8'h00;
        chk("bp_frozen", frozen, 1);
        chk("bp_ovr", overrun, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("bp_release", result_valid, 0);
        strobe(8'h01);
        strobe(8'h01);
        wait_valid(lat);
        chk("bp2_id", class_id, 0);
        chk("bp2_cnt", class_count, 2);
        chk("bp2_ovr", overrun, 1);
        enable = 1'b0;
        tick();
        chk("dis_ovr", overrun, 0);
        chk("dis_valid", result_valid, 0);

        // Abort mid-window, then a fresh window; window_len change mid-window is ignored
        result_ready = 1'b1;
        start(8'd4);
        for (int k = 0; k < 3; k++) strobe(8'h01);
        start(8'd4);
        strobe(8'h01);
        window_len = 8'd2;
        for (int k = 0; k < 3; k++) strobe(8'h01);
        wait_valid(lat);
        chk("abort_lat", lat, 8);
        chk("abort_cnt", class_count, 4);
        chk("abort_id", class_id, 0);
        tick();

        // Asynchronous reset during the scan
        result_ready = 1'b0;
        start(8'd1);
        strobe(8'h02);
        tick();
        tick();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", result_valid, 0);
        chk("ar_id", class_id, 0);
        chk("ar_cnt", class_count, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", result_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
